btn_debounce: RTL and testbench

Conditions the raw board push-buttons and keys before they reach the game controller.
- Per channel: 2-FF synchronizer, counter-based debounce, registered press/release edge pulses.
- Sits between the board pins and gameControl in the divided clk domain (clock_div output).
- gameControl consumes clean levels and single-cycle pulses instead of bouncing pins.

---
 rtl/btn_debounce_pkg.sv | 20 ++
 rtl/btn_debounce_ch.sv | 138 +++++++++++++
 rtl/btn_debounce.sv | 42 ++++
 tb/tb_btn_debounce.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/btn_debounce_pkg.sv
// Shared types and constants for the button debouncer.
// Holds the channel FSM encoding, short simulation timings and a counter-width helper.
package btn_debounce_pkg;

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_CHECK  = 1'b1
  } db_state_e;

  // Short timings that keep simulations fast; the hardware uses the module defaults.
  localparam int SIM_N            = 5;
  localparam int SIM_DB_CYCLES    = 4;
  localparam int SIM_REPEAT_DELAY = 10;
  localparam int SIM_REPEAT_RATE  = 3;

  function automatic int cntWidth(input int maxVal);
    return (maxVal < 2) ? 1 : $clog2(maxVal + 1);
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One debounce channel: 2-FF synchronizer, STABLE/CHECK filter and registered edge pulses.
// Auto-repeat of btn_press is built only when BTN_REPEAT_EN is defined.
module btn_debounce_ch
  import btn_debounce_pkg::*;
#(
  parameter int DB_CYCLES = 100000,
  parameter int CNT_W     = 17
`ifdef BTN_REPEAT_EN
  ,
  parameter int REPEAT_DELAY = 500000,
  parameter int REPEAT_RATE  = 200000
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  logic             s1_q, s2_q;
  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             accept;
  logic             rptFire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= btn_i;
      s2_q <= s1_q;
    end
  end

  // A new level is accepted only after DB_CYCLES consecutive differing samples.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    accept  = 1'b0;
    case (state_q)
      ST_STABLE: begin
        if (s2_q != level_q) begin
          state_d = ST_CHECK;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d = '0;
        end
      end
      ST_CHECK: begin
        if (s2_q == level_q) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(DB_CYCLES - 1)) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
          level_d = s2_q;
          accept  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    press_d   = (accept & s2_q) | rptFire;
    release_d = accept & ~s2_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_STABLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

`ifdef BTN_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RPT_W   = cntWidth(RPT_MAX);

  logic [RPT_W-1:0] rptCnt_q, rptCnt_d;
  logic             rptArmed_q, rptArmed_d;

  // Counts held cycles; the first period is REPEAT_DELAY, later ones REPEAT_RATE.
  always_comb begin
    rptCnt_d   = rptCnt_q;
    rptArmed_d = rptArmed_q;
    rptFire    = 1'b0;
    if (!level_q || accept) begin
      rptCnt_d   = '0;
      rptArmed_d = 1'b0;
    end else if (rptCnt_q == (rptArmed_q ? RPT_W'(REPEAT_RATE - 1) : RPT_W'(REPEAT_DELAY - 1))) begin
      rptFire    = 1'b1;
      rptCnt_d   = '0;
      rptArmed_d = 1'b1;
    end else begin
      rptCnt_d = rptCnt_q + RPT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptCnt_q   <= '0;
      rptArmed_q <= 1'b0;
    end else begin
      rptCnt_q   <= rptCnt_d;
      rptArmed_q <= rptArmed_d;
    end
  end
`else
  assign rptFire = 1'b0;
`endif

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/btn_debounce.sv
// N independent debounce channels between the board buttons and the game controller.
// Define BTN_REPEAT_EN to add held-button auto-repeat on btn_press_o.
module btn_debounce
  import btn_debounce_pkg::*;
#(
  parameter int N         = 5,
  parameter int DB_CYCLES = 100000,
  parameter int CNT_W     = 17
`ifdef BTN_REPEAT_EN
  ,
  parameter int REPEAT_DELAY = 500000,
  parameter int REPEAT_RATE  = 200000
`endif
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] btn_in_i,
  output logic [N-1:0] btn_level_o,
  output logic [N-1:0] btn_press_o,
  output logic [N-1:0] btn_release_o
);

  for (genvar g = 0; g < N; g++) begin : gen_ch
    btn_debounce_ch #(
      .DB_CYCLES   (DB_CYCLES),
      .CNT_W       (CNT_W)
`ifdef BTN_REPEAT_EN
      ,
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE (REPEAT_RATE)
`endif
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .btn_i    (btn_in_i[g]),
      .level_o  (btn_level_o[g]),
      .press_o  (btn_press_o[g]),
      .release_o(btn_release_o[g])
    );
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: directed scenarios plus random bouncing against a sample-window model.
// Honours BTN_REPEAT_EN when it is defined for the build.
module tb_btn_debounce;
   import btn_debounce_pkg::*;

   localparam int N  = SIM_N;
   localparam int DB = SIM_DB_CYCLES;

   logic         clk;
   logic         rst;
   logic [N-1:0] btnIn;
   logic [N-1:0] btnLevel;
   logic [N-1:0] btnPress;
   logic [N-1:0] btnRelease;

   int           checkCount;
   int           passCount;
   int           failCount;

   logic [N-1:0] smpQ[$];
   logic [N-1:0] expLevel;
   logic [N-1:0] expPress;
   logic [N-1:0] expRelease;
   int           heldCycles[N];
   logic [N-1:0] cur;

   btn_debounce #(
      .N           (N),
      .DB_CYCLES   (DB),
      .CNT_W       (cntWidth(DB))
`ifdef BTN_REPEAT_EN
      ,
      .REPEAT_DELAY(SIM_REPEAT_DELAY),
      .REPEAT_RATE (SIM_REPEAT_RATE)
`endif
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .btn_in_i     (btnIn),
      .btn_level_o  (btnLevel),
      .btn_press_o  (btnPress),
      .btn_release_o(btnRelease)
   );

   // Free-running 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model reset: synchronizer history reads as zeros, every output cleared.
   task automatic modelReset();
      smpQ.delete();
      for (int i = 0; i < DB + 2; i++) smpQ.push_back('0);
      expLevel   = '0;
      expPress   = '0;
      expRelease = '0;
      for (int c = 0; c < N; c++) heldCycles[c] = 0;
   endtask

   // Model edge: the filter sees the sample from two edges back; a level is accepted
   // once the last DB seen samples all differ from the current level.
   task automatic modelEdge(input logic [N-1:0] smp);
      bit allDiff;
      int idx;
      smpQ.push_back(smp);
      expPress   = '0;
      expRelease = '0;
      for (int c = 0; c < N; c++) begin
         allDiff = 1'b1;
         for (int j = 0; j < DB; j++) begin
            idx = smpQ.size() - 3 - j;
            if (smpQ[idx][c] == expLevel[c]) allDiff = 1'b0;
         end
         if (allDiff) begin
            if (expLevel[c] == 1'b0) begin
               expPress[c]   = 1'b1;
               heldCycles[c] = 0;
            end else begin
               expRelease[c] = 1'b1;
            end
            expLevel[c] = ~expLevel[c];
         end
`ifdef BTN_REPEAT_EN
         else if (expLevel[c]) begin
            heldCycles[c]++;
            if (heldCycles[c] == SIM_REPEAT_DELAY ||
                (heldCycles[c] > SIM_REPEAT_DELAY &&
                 (heldCycles[c] - SIM_REPEAT_DELAY) % SIM_REPEAT_RATE == 0))
               expPress[c] = 1'b1;
         end
`endif
      end
   endtask

   task automatic checkVec(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
      checkCount++;
      assert (obs === exp) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic checkOutput(input string tag);
      checkVec({tag, "_level"}, btnLevel, expLevel);
      checkVec({tag, "_press"}, btnPress, expPress);
      checkVec({tag, "_release"}, btnRelease, expRelease);
      checkVec({tag, "_exclusive"}, btnPress & btnRelease, '0);
   endtask

   // Drive a level for n edges, advancing the model and checking 1 ns after each edge.
   task automatic applyStimulus(input logic [N-1:0] v, input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         btnIn = v;
         @(posedge clk);
         if (rst) modelReset();
         else     modelEdge(v);
         #1;
         checkOutput(tag);
      end
   endtask

   // Outputs must clear as soon as reset rises, without waiting for a clock edge.
   task automatic applyReset(input int n);
      rst = 1'b1;
      modelReset();
      #1;
      checkOutput("reset_async");
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         modelReset();
         #1;
         checkOutput("reset_hold");
      end
      rst = 1'b0;
   endtask

   initial begin
      checkCount = 0;
      passCount  = 0;
      failCount  = 0;
      btnIn      = '0;
      cur        = '0;
      modelReset();

      applyReset(3);
      checkVec("reset_level_const", btnLevel, 5'b00000);
      applyStimulus(5'b00000, 3, "idle");

      // Clean press on channel 0: accepted on the sixth edge after the change.
      applyStimulus(5'b00001, 5, "press0_wait");
      checkVec("press0_before_level", btnLevel, 5'b00000);
      applyStimulus(5'b00001, 1, "press0_accept");
      checkVec("press0_level", btnLevel, 5'b00001);
      checkVec("press0_pulse", btnPress, 5'b00001);
      applyStimulus(5'b00001, 1, "press0_after");
      checkVec("press0_pulse_end", btnPress, 5'b00000);

      // Channel 1 bounces in 2-cycle chunks, then settles high.
      applyStimulus(5'b00011, 2, "bounce1");
      applyStimulus(5'b00001, 2, "bounce1");
      applyStimulus(5'b00011, 2, "bounce1");
      applyStimulus(5'b00001, 2, "bounce1");
      applyStimulus(5'b00011, 5, "bounce1_settle");
      checkVec("bounce1_no_level", btnLevel, 5'b00001);
      applyStimulus(5'b00011, 1, "bounce1_accept");
      checkVec("bounce1_level", btnLevel, 5'b00011);
      checkVec("bounce1_pulse", btnPress, 5'b00010);

      // Release channel 0 while channel 1 stays held.
      applyStimulus(5'b00010, 5, "release0_wait");
      applyStimulus(5'b00010, 1, "release0_accept");
      checkVec("release0_pulse", btnRelease, 5'b00001);
      checkVec("release0_level", btnLevel, 5'b00010);
      checkVec("release0_no_press", btnPress, 5'b00000);
      applyStimulus(5'b00000, 8, "release_all");

      // Simultaneous presses produce simultaneous pulses.
      applyStimulus(5'b10101, 5, "simul_wait");
      applyStimulus(5'b10101, 1, "simul_accept");
      checkVec("simul_pulse", btnPress, 5'b10101);
      applyStimulus(5'b10101, 1, "simul_after");
      checkVec("simul_pulse_end", btnPress, 5'b00000);
      applyStimulus(5'b00000, 8, "simul_release");

      // Reset while channel 2 is mid-check; channel 0 is already accepted.
      applyStimulus(5'b00001, 6, "pre_reset");
      applyStimulus(5'b00101, 2, "midcheck");
      applyReset(2);
      checkVec("midcheck_cleared", btnLevel, 5'b00000);
      applyStimulus(5'b00101, 5, "post_reset_wait");
      checkVec("post_reset_no_level", btnLevel, 5'b00000);
      applyStimulus(5'b00101, 1, "post_reset_accept");
      checkVec("post_reset_pulse", btnPress, 5'b00101);
      applyStimulus(5'b00000, 8, "post_reset_release");

      // Long hold on channel 3 exercises auto-repeat when it is built in.
      applyStimulus(5'b01000, 35, "hold3");
      applyStimulus(5'b00000, 10, "hold3_release");

      // Random bouncing on all channels with occasional resets.
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 199) == 0) applyReset(int'($urandom_range(1, 3)));
         for (int b = 0; b < N; b++)
            if ($urandom_range(0, 5) == 0) cur[b] = ~cur[b];
         applyStimulus(cur, 1, "rand");
      end
      applyStimulus(5'b00000, 8, "final");

      if (failCount != 0) $display("[TB] %0d comparisons disagreed", failCount);
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
